// File: rtl/router_pkg.sv
// router_pkg: shared constants and receiver FSM encoding for the router egress blocks
package router_pkg;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int ADDR_W      = 2;
    localparam int LEN_W       = 6;
    localparam int DATA_W      = 8;
    typedef enum logic [1:0] {IDLE, HDR, BODY} rx_state_t;
endpackage

// File: rtl/router_pkt_rx_if.sv
// router_pkt_rx_if: router port FIFO handshake plus parsed packet results
interface router_pkt_rx_if #(parameter int CNT_W = 16) ();
    import router_pkg::*;
    logic              en;
    logic              vld_out;
    logic [DATA_W-1:0] data_out;
    logic              read_enb;
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;
    logic              pkt_done;
    logic [ADDR_W-1:0] pkt_addr;
    logic [LEN_W-1:0]  pkt_len;
    logic              parity_err;
    logic              timeout_err;
    logic [CNT_W-1:0]  pkt_count;
    modport master (
        input  en, vld_out, data_out,
        output read_enb, byte_valid, byte_data, pkt_done, pkt_addr, pkt_len,
               parity_err, timeout_err, pkt_count
    );
    modport slave (
        output en, vld_out, data_out,
        input  read_enb, byte_valid, byte_data, pkt_done, pkt_addr, pkt_len,
               parity_err, timeout_err, pkt_count
    );
endinterface

// File: rtl/router_rx_parity.sv
// router_rx_parity: running XOR of header and payload, compared against the parity byte
module router_rx_parity import router_pkg::*; (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              fold,
    input  logic [DATA_W-1:0] din,
    output logic              mismatch
);
    logic [DATA_W-1:0] acc;
    // accumulator: clear wins over load, load over fold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) acc <= '0;
        else acc <= clear ? '0 : load ? din : fold ? acc ^ din : acc;
    end
    assign mismatch = acc != din;
endmodule

// File: rtl/router_pkt_rx.sv
// router_pkt_rx: drains one router output port and parses header, payload and parity
module router_pkt_rx import router_pkg::*; #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic           clock,
    input  logic           reset,
    router_pkt_rx_if.master bus
);
    localparam int IW = $clog2(TIMEOUT + 1);
    rx_state_t        state, state_nxt;
    logic             rd_q;
    logic [6:0]       issued, remaining, rcvd;
    logic [IW-1:0]    idle_cnt;
    logic [CNT_W-1:0] cnt;
    logic             arrive, is_par, timeout_hit, par_mis;
    assign arrive      = state == BODY && rd_q;
    assign is_par      = arrive && rcvd == remaining - 7'd1;
    assign timeout_hit = state == BODY && !rd_q && idle_cnt == IW'(TIMEOUT - 1);
    assign bus.read_enb = !reset && bus.vld_out && bus.en &&
                          (state == IDLE || (state == BODY && issued < remaining && !timeout_hit));
    assign bus.pkt_count = cnt;
    router_rx_parity u_parity (
        .clock    (clock),
        .reset    (reset),
        .clear    (is_par || timeout_hit),
        .load     (state == HDR),
        .fold     (arrive && !is_par),
        .din      (bus.data_out),
        .mismatch (par_mis)
    );
    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: header read, one bubble in HDR, body until parity or timeout
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (bus.read_enb ? HDR : IDLE) :
                    state == HDR  ? BODY :
                    (is_par || timeout_hit) ? IDLE : BODY;
    end
    // datapath: header capture, byte counting, payload streaming and status
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q            <= 1'b0;
            issued          <= '0;
            remaining       <= '0;
            rcvd            <= '0;
            idle_cnt        <= '0;
            cnt             <= '0;
            bus.byte_valid  <= 1'b0;
            bus.byte_data   <= '0;
            bus.pkt_done    <= 1'b0;
            bus.pkt_addr    <= '0;
            bus.pkt_len     <= '0;
            bus.parity_err  <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            rd_q           <= bus.read_enb;
            bus.byte_valid <= 1'b0;
            bus.pkt_done   <= 1'b0;
            if (state == HDR) begin
                bus.pkt_len  <= bus.data_out[HDR_LEN_MSB:HDR_LEN_LSB];
                bus.pkt_addr <= bus.data_out[ADDR_W-1:0];
                remaining    <= {1'b0, bus.data_out[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
                issued       <= '0;
                rcvd         <= '0;
                idle_cnt     <= '0;
            end
            if (state == BODY) begin
                if (bus.read_enb) issued <= issued + 7'd1;
                if (arrive) rcvd <= rcvd + 7'd1;
                idle_cnt <= arrive ? '0 : idle_cnt + IW'(1);
                if (arrive && !is_par) begin
                    bus.byte_valid <= 1'b1;
                    bus.byte_data  <= bus.data_out;
                end
                if (is_par || timeout_hit) begin
                    bus.pkt_done    <= 1'b1;
                    bus.parity_err  <= is_par && par_mis;
                    bus.timeout_err <= timeout_hit;
                    if (is_par && !par_mis) cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/router_pkt_rx.md
# router_pkt_rx

Packet receiver for one router output port. Drains the port's output FIFO through the `vld_out`/`read_enb` handshake and parses each packet into header, payload and parity. Streams payload bytes, checks parity and reports per-packet status. One instance per output port (0..2) at the router egress, in both synthesizable sinks and the top-level bench.

## Interface
Parameters:
- `TIMEOUT`, 32: idle cycles mid-packet before the packet is abandoned. Matches the router FIFO soft-reset window; must be ≥ 2.
- `CNT_W`, 16: width of the packet counter.

Ports:
- `clock`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  receive enable; when low, no new reads are issued.
- `vld_out`  in  1  router port FIFO non-empty.
- `data_out`  in  8  router port data, valid the cycle after a sampled read.
- `read_enb`  out  1  pop request to the router port; combinational.
- `byte_valid`  out  1  one-cycle strobe, payload byte on `byte_data`.
- `byte_data`  out  8  payload byte (registered).
- `pkt_done`  out  1  one-cycle strobe at end of packet (normal or abandoned).
- `pkt_addr`  out  2  header address field of the last packet.
- `pkt_len`  out  6  header length field of the last packet.
- `parity_err`  out  1  valid with `pkt_done`; received parity ≠ XOR of header and payload.
- `timeout_err`  out  1  valid with `pkt_done`; packet abandoned on timeout.
- `pkt_count`  out  CNT_W  packets completed without any error; wraps at 2^CNT_W.

## Operation
- FSM states: IDLE, HDR, BODY.
- IDLE: `read_enb = vld_out & en`. A sampled read moves to HDR.
- HDR: `read_enb = 0`. The header byte arrives this cycle and is captured:
  - `pkt_len = data_out[7:2]`, `pkt_addr = data_out[1:0]`.
  - `remaining = pkt_len + 1` (payload plus parity, 7-bit).
  - `issued = 0`, `xor_acc = header`.
  - Go to BODY.
- BODY: `read_enb = vld_out & en & (issued < remaining)`. Each sampled read increments `issued`.
  - `rd_q` is the registered copy of `read_enb`. A byte arrives on each cycle where `rd_q = 1`.
  - Arriving bytes are counted in `rcvd`.
  - When `rcvd < remaining - 1`, the byte is payload: pulse `byte_valid`, drive `byte_data`, and fold the byte into `xor_acc`.
  - When `rcvd == remaining - 1`, the byte is parity: compare it with `xor_acc`, pulse `pkt_done`, and return to IDLE.
- Length 0: the first body byte is parity and no `byte_valid` pulses.
- Error accounting:
  - `parity_err` and `timeout_err` update only on `pkt_done` cycles and hold between packets.
  - `pkt_count` increments only on an error-free `pkt_done`.
- Timeout: an idle counter runs in BODY.
  - It clears on any byte arrival and increments otherwise.
  - Reaching `TIMEOUT` pulses `pkt_done` with `timeout_err = 1` and `parity_err = 0`, then returns to IDLE.
  - Partial payload already streamed is not retracted.
- `en` low mid-packet only stalls reads. The timeout still runs.

## Timing
- Reset: FSM in IDLE and all counters zero. Every output is 0: `read_enb`, `byte_valid`, `byte_data`, `pkt_done`, `pkt_addr`, `pkt_len`, `parity_err`, `timeout_err`, `pkt_count`.
- Read-to-data latency is 1 cycle. `byte_valid` is registered, so it appears 2 cycles after the sampled read.
- `pkt_done` is registered: 1 cycle after the parity byte arrives.
- `read_enb` is never high in HDR, so the header is always followed by exactly one bubble.
- Back-to-back packets: IDLE may issue the next header read in the cycle after the parity byte arrives. Minimum gap is zero idle cycles between packets.
- Reads are never issued beyond `remaining`, so the next packet's header is never consumed early.
- `reset` mid-packet: immediate return to IDLE. No `pkt_done` is produced; the partial packet is dropped silently.
- Simultaneous events: byte arrival and timeout threshold in the same cycle → the arrival wins and the idle counter clears.

## Structure
- Shared package `router_pkg`:
  - `HDR_LEN_MSB = 7`, `HDR_LEN_LSB = 2`, `ADDR_W = 2`, `LEN_W = 6`, `DATA_W = 8`.
  - FSM state encoding `rx_state_t`.
- Sub-module `router_rx_parity`: running XOR accumulator with `clear`, `load`, `fold` and `compare` operations.
- All remaining logic stays in the top module.

## Test plan
- Reset, then a packet with header `0x38` (len 14, addr 0), 14 random payload bytes and correct parity → 14 `byte_valid` pulses in order; `pkt_done` with `pkt_len = 14`, `pkt_addr = 0`, `parity_err = 0`; `pkt_count = 1`.
- Packet with len 16, addr 1, whose parity byte has bit 0 flipped → `pkt_done` with `parity_err = 1`; `pkt_count` unchanged.
- Len-0 packet (header `0x02`, then parity `0x02`) → no `byte_valid`; `pkt_done` with no error.
- `vld_out` drops after 5 of 10 payload bytes and stays low for `TIMEOUT` cycles → 5 `byte_valid` pulses, then `pkt_done` with `timeout_err = 1`; FSM back in IDLE; the next packet is received cleanly.
- Two packets queued back-to-back (len 3, then len 63) with `vld_out` held high → no over-read, correct byte counts for both, exactly one bubble after each header, and `pkt_count = 2`.
- `reset` asserted mid-payload, then one full packet → no `pkt_done` for the aborted packet, and all outputs 0 while `reset` is high. After release, the full packet is received: `pkt_count = 1`.
